// File: rtl/sweep_ctrl.sv
// Frequency-sweep sequencer driving a sine generator's phase increment.
// Steps cnt_incr from start to stop, holding each value for dwell+1 cycles.
module sweep_ctrl #(
  parameter int COUNT_WIDTH = 8,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   loop,
  input  logic [COUNT_WIDTH-1:0] start_incr,
  input  logic [COUNT_WIDTH-1:0] stop_incr,
  input  logic [COUNT_WIDTH-1:0] step,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [COUNT_WIDTH-1:0] cnt_incr,
  output logic                   en,
  output logic                   busy,
  output logic                   step_pulse,
  output logic                   done
);

  localparam int CW = COUNT_WIDTH;
  localparam int DW = DWELL_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [DW-1:0] D_ONE = 1;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          pulse_q, pulse_d;
  logic          done_q, done_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  logic [CW-1:0] start_q, start_d;
  logic [CW-1:0] stop_q, stop_d;
  logic [CW-1:0] step_q, step_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          loop_q, loop_d;
  logic          up_q, up_d;

  logic [CW:0]   sum_w;
  logic [CW:0]   lim_w;
  logic [CW-1:0] nxt_w;

  // One guard bit keeps both the sum and the down-limit free of wrap.
  always_comb begin
    sum_w = {1'b0, cnt_q} + {1'b0, step_q};
    lim_w = {1'b0, stop_q} + {1'b0, step_q};
    if (up_q) begin
      if (sum_w > {1'b0, stop_q}) nxt_w = stop_q;
      else                        nxt_w = sum_w[CW-1:0];
    end else begin
      if ({1'b0, cnt_q} < lim_w)  nxt_w = stop_q;
      else                        nxt_w = cnt_q - step_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    busy_d  = busy_q;
    pulse_d = 1'b0;
    done_d  = 1'b0;
    dcnt_d  = dcnt_q;
    start_d = start_q;
    stop_d  = stop_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    loop_d  = loop_q;
    up_d    = up_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort && (step != '0)) begin
          start_d = start_incr;
          stop_d  = stop_incr;
          step_d  = step;
          dwell_d = dwell;
          loop_d  = loop;
          up_d    = (stop_incr >= start_incr);
          cnt_d   = start_incr;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          dcnt_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          dcnt_d  = '0;
        end else if (dcnt_q == dwell_q) begin
          dcnt_d = '0;
          if (cnt_q != stop_q) begin
            cnt_d   = nxt_w;
            pulse_d = 1'b1;
          end else if (loop_q) begin
            cnt_d   = start_q;
            pulse_d = 1'b1;
          end else begin
            state_d = S_DONE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q + D_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (abort) cnt_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        dcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      dcnt_q  <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      loop_q  <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      dcnt_q  <= dcnt_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      loop_q  <= loop_d;
      up_q    <= up_d;
    end
  end

  assign cnt_incr   = cnt_q;
  assign en         = en_q;
  assign busy       = busy_q;
  assign step_pulse = pulse_q;
  assign done       = done_q;

endmodule
